mode_cmd_controller: RTL and testbench



---
 rtl/mode_cmd_pkg.sv | 24 ++
 rtl/btn_event.sv | 94 +++++++++
 rtl/mode_cmd_controller.sv | 226 ++++++++++++++++++++++
 tb/tb_mode_cmd_controller.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mode_cmd_pkg.sv
// ---------------------------------------------------------------------------
// mode_cmd_pkg
// Shared constants and helpers for the mode/command button controller.
//   MODE_IDLE          index of the idle/animation mode (no run/clear function)
//   DEFAULT_NUM_MODES  default number of modes (idle + minutes + stopwatch)
//   calc_mode_w()      width of the mode index, never less than one bit
// ---------------------------------------------------------------------------
package mode_cmd_pkg;

  localparam int MODE_IDLE         = 0;
  localparam int DEFAULT_NUM_MODES = 3;

  // $clog2(2) is 1 but $clog2(1) is 0; a mode index always needs a bit.
  function automatic int calc_mode_w(input int num_modes);
    int w;
    w = $clog2(num_modes);
    if (w < 1) begin
      return 1;
    end else begin
      return w;
    end
  endfunction

endpackage

// File: rtl/btn_event.sv
// ---------------------------------------------------------------------------
// btn_event
// Conditions one raw push button: two-flop synchroniser, counter debounce,
// press (debounced rising edge) and long-press detection.
// Ports:
//   clk      in   system clock
//   reset    in   synchronous, active-high reset
//   btn_raw  in   asynchronous raw button level
//   level    out  debounced button level
//   press    out  one-cycle pulse when level rises
//   long     out  one-cycle pulse once level has been high LONG_CYC cycles;
//                 fires once per hold, re-armed when level drops
// ---------------------------------------------------------------------------
module btn_event #(
  parameter int DEB_CYC  = 1_000_000,
  parameter int LONG_CYC = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic press,
  output logic long
);

  localparam int DEB_W  = $clog2(DEB_CYC + 1);
  localparam int HOLD_W = $clog2(LONG_CYC + 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYC);

  logic [1:0]        sync_r;
  logic              level_r;
  logic              press_r;
  logic              long_r;
  logic [DEB_W-1:0]  deb_cnt_r;
  logic [HOLD_W-1:0] hold_cnt_r;
  logic              synced_s;
  logic              flip_s;

  assign synced_s = sync_r[1];
  // The current cycle is the DEB_CYC-th consecutive one differing from level.
  assign flip_s   = (synced_s != level_r) && (deb_cnt_r == DEB_LAST);

  // Two-flop synchroniser for the asynchronous button input.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], btn_raw};
    end
  end

  // Debounce counter; any agreeing sample restarts the stability window.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_r   <= 1'b0;
      press_r   <= 1'b0;
      deb_cnt_r <= '0;
    end else begin
      press_r <= flip_s && synced_s;
      if (synced_s == level_r) begin
        deb_cnt_r <= '0;
      end else if (flip_s) begin
        level_r   <= synced_s;
        deb_cnt_r <= '0;
      end else begin
        deb_cnt_r <= deb_cnt_r + DEB_W'(1);
      end
    end
  end

  // Hold counter saturates at LONG_CYC so the long pulse cannot repeat.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt_r <= '0;
      long_r     <= 1'b0;
    end else begin
      long_r <= level_r && (hold_cnt_r == HOLD_LAST);
      if (!level_r) begin
        hold_cnt_r <= '0;
      end else if (hold_cnt_r != HOLD_MAX) begin
        hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
      end else begin
        hold_cnt_r <= hold_cnt_r;
      end
    end
  end

  assign level = level_r;
  assign press = press_r;
  assign long  = long_r;

endmodule

// File: rtl/mode_cmd_controller.sv
// ---------------------------------------------------------------------------
// mode_cmd_controller
// Button front end for the counter/display datapath. Three debounced buttons
// select a wrapping mode, toggle a per-mode run flag and issue per-mode or
// global clear pulses. A stopped non-idle mode left alone for TIMEOUT_S
// seconds falls back to mode 0. The display word of the current mode is
// muxed onto seg_data.
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   btn_mode   in   raw mode button
//   btn_run    in   raw run/stop button
//   btn_clr    in   raw clear button
//   disp_data  in   packed display words, mode m at [m*DATA_W +: DATA_W]
//   mode       out  current mode index
//   mode_led   out  one-hot of mode (one cycle behind mode)
//   seg_data   out  display word of mode (one cycle behind mode)
//   run_stop   out  per-mode run flag, bit 0 always 0
//   clear      out  per-mode one-cycle clear pulses, bit 0 always 0
//   anim_mode  out  high while in mode 0 (one cycle behind mode)
// ---------------------------------------------------------------------------
module mode_cmd_controller
  import mode_cmd_pkg::*;
#(
  parameter int NUM_MODES = DEFAULT_NUM_MODES,
  parameter int DATA_W    = 14,
  parameter int CLK_HZ    = 100_000_000,
  parameter int DEB_CYC   = 1_000_000,
  parameter int LONG_CYC  = 100_000_000,
  parameter int TIMEOUT_S = 30,
  parameter int MODE_W    = calc_mode_w(NUM_MODES)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        btn_mode,
  input  logic                        btn_run,
  input  logic                        btn_clr,
  input  logic [NUM_MODES*DATA_W-1:0] disp_data,
  output logic [MODE_W-1:0]           mode,
  output logic [NUM_MODES-1:0]        mode_led,
  output logic [DATA_W-1:0]           seg_data,
  output logic [NUM_MODES-1:0]        run_stop,
  output logic [NUM_MODES-1:0]        clear,
  output logic                        anim_mode
);

  localparam int TICK_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int IDLE_W = (TIMEOUT_S > 0) ? $clog2(TIMEOUT_S + 1) : 1;
  localparam logic [TICK_W-1:0]    TICK_LAST = TICK_W'(CLK_HZ - 1);
  localparam logic [IDLE_W-1:0]    IDLE_MAX  = IDLE_W'(TIMEOUT_S);
  localparam logic [MODE_W-1:0]    MODE_ZERO = MODE_W'(MODE_IDLE);
  localparam logic [MODE_W-1:0]    MODE_LAST = MODE_W'(NUM_MODES - 1);
  localparam logic [NUM_MODES-1:0] CLR_ALL   = {{(NUM_MODES-1){1'b1}}, 1'b0};

  // Button events
  logic [2:0] level_unused_s;  // debounced levels are not consumed here
  logic       mode_press_s;
  logic       mode_long_s;
  logic       run_press_s;
  logic       run_long_s;
  logic       clr_press_s;
  logic       clr_long_s;

  // State
  logic [MODE_W-1:0]    mode_r;
  logic [NUM_MODES-1:0] run_stop_r;
  logic [NUM_MODES-1:0] clear_r;
  logic [IDLE_W-1:0]    idle_sec_r;
  logic [TICK_W-1:0]    tick_cnt_r;
  logic [NUM_MODES-1:0] led_r;
  logic [DATA_W-1:0]    seg_r;
  logic                 anim_r;

  // Next-state and decode
  logic [MODE_W-1:0]    mode_next_s;
  logic [NUM_MODES-1:0] run_next_s;
  logic [NUM_MODES-1:0] clear_next_s;
  logic [IDLE_W-1:0]    idle_next_s;
  logic [NUM_MODES-1:0] cur_sel_s;
  logic [DATA_W-1:0]    seg_next_s;
  logic                 tick_s;
  logic                 any_evt_s;
  logic                 in_idle_s;
  logic                 cur_running_s;
  logic                 hold_idle_s;
  logic                 timeout_s;

  btn_event #(.DEB_CYC(DEB_CYC), .LONG_CYC(LONG_CYC)) u_btn_mode (
    .clk(clk), .reset(reset), .btn_raw(btn_mode),
    .level(level_unused_s[0]), .press(mode_press_s), .long(mode_long_s)
  );

  btn_event #(.DEB_CYC(DEB_CYC), .LONG_CYC(LONG_CYC)) u_btn_run (
    .clk(clk), .reset(reset), .btn_raw(btn_run),
    .level(level_unused_s[1]), .press(run_press_s), .long(run_long_s)
  );

  btn_event #(.DEB_CYC(DEB_CYC), .LONG_CYC(LONG_CYC)) u_btn_clr (
    .clk(clk), .reset(reset), .btn_raw(btn_clr),
    .level(level_unused_s[2]), .press(clr_press_s), .long(clr_long_s)
  );

  assign tick_s        = (tick_cnt_r == TICK_LAST);
  assign any_evt_s     = mode_press_s | mode_long_s | run_press_s |
                         run_long_s   | clr_press_s | clr_long_s;
  assign in_idle_s     = (mode_r == MODE_ZERO);
  assign cur_running_s = |(run_stop_r & cur_sel_s);
  // Activity, idle mode or a running counter all hold the idle timer at 0.
  assign hold_idle_s   = any_evt_s | in_idle_s | cur_running_s;
  assign timeout_s     = !hold_idle_s && (idle_sec_r == IDLE_MAX);

  // One-hot decode of the current mode; also drives the LED register.
  always_comb begin
    cur_sel_s = '0;
    for (int m = 0; m < NUM_MODES; m++) begin
      if (mode_r == MODE_W'(m)) begin
        cur_sel_s[m] = 1'b1;
      end else begin
        cur_sel_s[m] = 1'b0;
      end
    end
  end

  // Next-state logic; run and clear act on the mode before this update.
  always_comb begin
    mode_next_s  = mode_r;
    run_next_s   = run_stop_r;
    clear_next_s = '0;
    idle_next_s  = idle_sec_r;

    // Long press arrives after its own short press and forces mode 0.
    if (mode_long_s) begin
      mode_next_s = MODE_ZERO;
    end else if (mode_press_s) begin
      mode_next_s = (mode_r == MODE_LAST) ? MODE_ZERO : mode_r + MODE_W'(1);
    end else if (timeout_s) begin
      mode_next_s = MODE_ZERO;
    end else begin
      mode_next_s = mode_r;
    end

    if (clr_long_s) begin
      run_next_s = '0;
    end else if (run_press_s && !in_idle_s) begin
      run_next_s = run_stop_r ^ cur_sel_s;
    end else begin
      run_next_s = run_stop_r;
    end
    run_next_s[0] = 1'b0;

    if (clr_long_s) begin
      clear_next_s = CLR_ALL;
    end else if (clr_press_s && !in_idle_s) begin
      clear_next_s = cur_sel_s & CLR_ALL;
    end else begin
      clear_next_s = '0;
    end

    if (hold_idle_s || timeout_s) begin
      idle_next_s = '0;
    end else if (tick_s && (idle_sec_r != IDLE_MAX)) begin
      idle_next_s = idle_sec_r + IDLE_W'(1);
    end else begin
      idle_next_s = idle_sec_r;
    end
  end

  // Display word mux for the current mode.
  always_comb begin
    seg_next_s = '0;
    for (int m = 0; m < NUM_MODES; m++) begin
      if (cur_sel_s[m]) begin
        seg_next_s = disp_data[m*DATA_W +: DATA_W];
      end else begin
        seg_next_s = seg_next_s;
      end
    end
  end

  // Free-running one-second tick divider.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_r <= '0;
    end else if (tick_s) begin
      tick_cnt_r <= '0;
    end else begin
      tick_cnt_r <= tick_cnt_r + TICK_W'(1);
    end
  end

  // Mode, run flags, clear pulses and idle timer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_r     <= MODE_ZERO;
      run_stop_r <= '0;
      clear_r    <= '0;
      idle_sec_r <= '0;
    end else begin
      mode_r     <= mode_next_s;
      run_stop_r <= run_next_s;
      clear_r    <= clear_next_s;
      idle_sec_r <= idle_next_s;
    end
  end

  // Display-side outputs, registered one cycle behind mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      led_r  <= NUM_MODES'(1);
      seg_r  <= '0;
      anim_r <= 1'b1;
    end else begin
      led_r  <= cur_sel_s;
      seg_r  <= seg_next_s;
      anim_r <= in_idle_s;
    end
  end

  assign mode      = mode_r;
  assign mode_led  = led_r;
  assign seg_data  = seg_r;
  assign run_stop  = run_stop_r;
  assign clear     = clear_r;
  assign anim_mode = anim_r;

endmodule

// File: tb/tb_mode_cmd_controller.sv
// ---------------------------------------------------------------------------
// tb_mode_cmd_controller
// Self-checking bench: directed scenarios followed by random button traffic,
// every output compared each cycle against a behavioural model of the
// button, mode, run/clear and timeout rules.
// ---------------------------------------------------------------------------
module tb_mode_cmd_controller;

  localparam int NM   = 4;
  localparam int DW   = 14;
  localparam int HZ   = 100;
  localparam int DEB  = 4;
  localparam int LONG = 50;
  localparam int TO   = 3;

  logic          clk;
  logic          reset;
  logic          btn_mode;
  logic          btn_run;
  logic          btn_clr;
  logic [NM*DW-1:0] disp_data;
  logic [1:0]    mode;
  logic [NM-1:0] mode_led;
  logic [DW-1:0] seg_data;
  logic [NM-1:0] run_stop;
  logic [NM-1:0] clear;
  logic          anim_mode;

  int n_checks = 0;
  int n_errors = 0;

  // Model state (represents the current cycle)
  int            m_c;
  int            m_mode;
  int            m_idle;
  bit            m_run [NM];
  bit            m_clear [NM];
  int            m_led;
  logic [DW-1:0] m_seg;
  int            m_anim;
  int            b_s0 [3];
  int            b_s1 [3];
  int            b_lvl [3];
  int            b_press [3];
  int            b_long [3];
  int            b_rise [3];
  int            b_hist [3][DEB];
  int            b_hist_n [3];

  mode_cmd_controller #(
    .NUM_MODES(NM), .DATA_W(DW), .CLK_HZ(HZ), .DEB_CYC(DEB),
    .LONG_CYC(LONG), .TIMEOUT_S(TO)
  ) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_run(btn_run),
    .btn_clr(btn_clr), .disp_data(disp_data), .mode(mode),
    .mode_led(mode_led), .seg_data(seg_data), .run_stop(run_stop),
    .clear(clear), .anim_mode(anim_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, m_c);
    end
  endtask

  task automatic model_reset();
    m_c = 0; m_mode = 0; m_idle = 0; m_led = 1; m_seg = '0; m_anim = 1;
    for (int i = 0; i < NM; i++) begin m_run[i] = 1'b0; m_clear[i] = 1'b0; end
    for (int b = 0; b < 3; b++) begin
      b_s0[b] = 0; b_s1[b] = 0; b_lvl[b] = 0; b_press[b] = 0; b_long[b] = 0;
      b_rise[b] = -1000000; b_hist_n[b] = 0;
    end
  endtask

  // Advance the model by one clock edge using the inputs now applied.
  task automatic model_update();
    int evt, freeze, tmo, tick, nm, synced, flip, nl;
    int raw [3];
    logic [NM*DW-1:0] sh;
    if (reset) begin
      model_reset();
      return;
    end
    raw[0] = int'(btn_mode); raw[1] = int'(btn_run); raw[2] = int'(btn_clr);
    evt = 0;
    for (int b = 0; b < 3; b++) if (b_press[b] != 0 || b_long[b] != 0) evt = 1;
    freeze = (evt != 0 || m_mode == 0 || m_run[m_mode]) ? 1 : 0;
    tmo    = (freeze == 0 && m_idle == TO) ? 1 : 0;
    tick   = ((m_c % HZ) == HZ - 1) ? 1 : 0;

    if (b_long[0] != 0)       nm = 0;
    else if (b_press[0] != 0) nm = (m_mode + 1) % NM;
    else if (tmo != 0)        nm = 0;
    else                      nm = m_mode;

    for (int i = 0; i < NM; i++) m_clear[i] = 1'b0;
    if (b_long[2] != 0) begin
      for (int i = 1; i < NM; i++) begin m_clear[i] = 1'b1; m_run[i] = 1'b0; end
    end else begin
      if (b_press[2] != 0 && m_mode != 0) m_clear[m_mode] = 1'b1;
      if (b_press[1] != 0 && m_mode != 0) m_run[m_mode] = !m_run[m_mode];
    end

    if (freeze != 0 || tmo != 0) m_idle = 0;
    else if (tick != 0 && m_idle < TO) m_idle = m_idle + 1;

    m_led  = 1 << m_mode;
    sh     = disp_data >> (m_mode * DW);
    m_seg  = sh[DW-1:0];
    m_anim = (m_mode == 0) ? 1 : 0;
    m_mode = nm;
    m_c    = m_c + 1;

    // Button model: level flips once the last DEB synchronised samples all disagree.
    for (int b = 0; b < 3; b++) begin
      synced = b_s1[b];
      for (int i = DEB - 1; i > 0; i--) b_hist[b][i] = b_hist[b][i-1];
      b_hist[b][0] = synced;
      if (b_hist_n[b] < DEB) b_hist_n[b]++;
      flip = (b_hist_n[b] == DEB) ? 1 : 0;
      for (int i = 0; i < DEB; i++) if (b_hist[b][i] == b_lvl[b]) flip = 0;
      nl = (flip != 0) ? 1 - b_lvl[b] : b_lvl[b];
      b_long[b]  = (b_lvl[b] == 1 && (m_c - b_rise[b]) == LONG) ? 1 : 0;
      b_press[b] = (nl == 1 && b_lvl[b] == 0) ? 1 : 0;
      if (b_press[b] != 0) b_rise[b] = m_c;
      b_lvl[b] = nl;
      b_s1[b]  = b_s0[b];
      b_s0[b]  = raw[b];
    end
  endtask

  task automatic compare_all();
    logic [NM-1:0] run_v, clr_v;
    for (int i = 0; i < NM; i++) begin run_v[i] = m_run[i]; clr_v[i] = m_clear[i]; end
    check("mode", 32'(mode), 32'(m_mode));
    check("mode_led", 32'(mode_led), 32'(m_led));
    check("seg_data", 32'(seg_data), 32'(m_seg));
    check("run_stop", 32'(run_stop), 32'(run_v));
    check("clear", 32'(clear), 32'(clr_v));
    check("anim_mode", 32'(anim_mode), 32'(m_anim));
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic press_btn(input int b, input int hold, input int gap);
    if (b == 0) btn_mode = 1'b1;
    else if (b == 1) btn_run = 1'b1;
    else btn_clr = 1'b1;
    repeat (hold) step();
    btn_mode = 1'b0; btn_run = 1'b0; btn_clr = 1'b0;
    repeat (gap) step();
  endtask

  initial begin
    int seq [5];
    int found;
    int kind, len, mask;
    logic [63:0] r64;
    seq[0] = 1; seq[1] = 2; seq[2] = 3; seq[3] = 0; seq[4] = 1;
    reset = 1'b1; btn_mode = 1'b0; btn_run = 1'b0; btn_clr = 1'b0;
    r64 = {$urandom, $urandom};
    disp_data = r64[NM*DW-1:0];
    step(); step();
    reset = 1'b0;
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_led", 32'(mode_led), 32'd1);
    check("rst_anim", 32'(anim_mode), 32'd1);
    check("rst_run", 32'(run_stop), 32'd0);

    // Glitch shorter than the debounce window, then clean wrapping presses
    btn_mode = 1'b1; repeat (3) step(); btn_mode = 1'b0; repeat (10) step();
    check("glitch_mode", 32'(mode), 32'd0);
    for (int i = 0; i < 5; i++) begin
      press_btn(0, 20, 10);
      check("wrap_mode", 32'(mode), 32'(seq[i]));
      if (i == 0) check("wrap_led", 32'(mode_led), 32'b0010);
    end

    // Per-mode run flags and display mux
    disp_data[2*DW +: DW] = 14'd1234;
    press_btn(1, 20, 10);
    check("run_m1", 32'(run_stop), 32'b0010);
    press_btn(0, 20, 10);
    press_btn(1, 20, 10);
    check("run_m2", 32'(run_stop), 32'b0110);
    check("seg_1234", 32'(seg_data), 32'd1234);

    // Short clear, then long clear stops everything
    press_btn(2, 20, 10);
    press_btn(2, 60, 10);
    check("clr_long_run", 32'(run_stop), 32'd0);

    // Timeout from a stopped mode 3; no timeout while running
    press_btn(0, 20, 10);
    repeat (400) step();
    check("timeout_mode", 32'(mode), 32'd0);
    check("timeout_anim", 32'(anim_mode), 32'd1);
    for (int i = 0; i < 3; i++) press_btn(0, 20, 10);
    press_btn(1, 20, 10);
    repeat (1000) step();
    check("running_mode", 32'(mode), 32'd3);
    press_btn(1, 20, 10);

    // Mode press landing exactly on the timeout cycle in mode 1
    press_btn(0, 20, 10);
    press_btn(0, 20, 10);
    found = 0;
    for (int w = 0; w < 1000 && found == 0; w++) begin
      if (m_idle == TO - 1 && (m_c % HZ) == HZ - DEB - 2) found = 1;
      else step();
    end
    check("align_wait", 32'(found), 32'd1);
    press_btn(0, 20, 10);
    check("tmo_vs_press", 32'(mode), 32'd2);
    repeat (150) step();
    check("idle_restart", 32'(mode), 32'd2);

    // Long mode press from mode 1, then reset while run is held
    for (int i = 0; i < 3; i++) press_btn(0, 20, 10);
    btn_mode = 1'b1;
    repeat (10) step();
    check("long_first", 32'(mode), 32'd2);
    repeat (50) step();
    check("long_zero", 32'(mode), 32'd0);
    btn_mode = 1'b0;
    repeat (10) step();
    btn_run = 1'b1;
    repeat (10) step();
    reset = 1'b1; step(); reset = 1'b0;
    check("midrst_mode", 32'(mode), 32'd0);
    check("midrst_led", 32'(mode_led), 32'd1);
    check("midrst_seg", 32'(seg_data), 32'd0);
    repeat (20) step();
    btn_run = 1'b0;
    repeat (10) step();

    // Random traffic against the model
    for (int it = 0; it < 150; it++) begin
      kind = int'($urandom_range(0, 19));
      if (kind == 0) begin
        reset = 1'b1; step(); reset = 1'b0;
      end else if (kind <= 2) begin
        r64 = {$urandom, $urandom};
        disp_data = r64[NM*DW-1:0];
        step();
      end else if (kind <= 4) begin
        repeat ($urandom_range(150, 350)) step();
      end else begin
        mask = int'($urandom_range(1, 7));
        kind = int'($urandom_range(0, 9));
        if (kind < 2) len = int'($urandom_range(1, 3));
        else if (kind < 8) len = int'($urandom_range(6, 30));
        else len = int'($urandom_range(52, 70));
        btn_mode = mask[0]; btn_run = mask[1]; btn_clr = mask[2];
        repeat (len) step();
        btn_mode = 1'b0; btn_run = 1'b0; btn_clr = 1'b0;
        repeat ($urandom_range(6, 20)) step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
